// File: rtl/operand_skew_loader.sv
// Serial operand loader: deserialises X/Y streams into word banks, then replays
// them as skewed diagonal wavefronts with per-lane valids for the systolic array.

module osl_stream #(
  parameter int D_W   = 8,
  parameter int NB    = 2,
  parameter int DEPTH = 8,
  parameter int LANES = 1,
  parameter int KW    = 4,
  parameter int TW    = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               ld,
  input  logic [LANES-1:0]   ser,
  input  logic [KW-1:0]      k,
  input  logic [TW-1:0]      t,
  input  logic               issue,
  output logic [NB*D_W-1:0]  words,
  output logic [NB-1:0]      valid,
  output logic               complete,
  output logic               ovf
);
  localparam int CPW = D_W / LANES;
  localparam int CW  = (CPW > 1) ? $clog2(CPW) : 1;
  localparam int AW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BW  = $clog2(NB + 1);
  localparam int BIW = (NB > 1) ? $clog2(NB) : 1;

  logic [D_W-1:0]                    sr, sr_n;
  logic [CW-1:0]                     cyc;
  logic [KW-1:0]                     a;
  logic [BW-1:0]                     b;
  logic [NB-1:0][DEPTH-1:0][D_W-1:0] bank;
  logic [NB-1:0][D_W-1:0]            w_q, w_n;
  logic [NB-1:0]                     v_n;
  logic [TW-1:0]                     idx;
  logic                              wdone;

  generate
    if (LANES == D_W) begin : g_full
      assign sr_n = ser;
    end else begin : g_shift
      assign sr_n = {ser, sr[D_W-1:LANES]};
    end
  endgenerate

  // The completing chunk is taken straight from ser so the word lands in the bank
  // on the same edge that finishes it.
  assign wdone    = ld && (cyc == CW'(CPW - 1));
  assign complete = (b == BW'(NB));
  assign ovf      = wdone && complete;
  assign words    = w_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr    <= '0;
      cyc   <= '0;
      a     <= '0;
      b     <= '0;
      w_q   <= '0;
      valid <= '0;
    end else begin
      if (clr) begin
        sr  <= '0;
        cyc <= '0;
        a   <= '0;
        b   <= '0;
      end else if (ld) begin
        sr  <= sr_n;
        cyc <= wdone ? '0 : cyc + 1'b1;
        if (wdone && !complete) begin
          if (a == k - 1'b1) begin
            a <= '0;
            b <= b + 1'b1;
          end else begin
            a <= a + 1'b1;
          end
        end
      end
      if (issue) begin
        w_q   <= w_n;
        valid <= v_n;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wdone && !complete) bank[b[BIW-1:0]][a[AW-1:0]] <= sr_n;
  end

  // Lane r sees word t-r while it lies inside [0, K).
  always_comb begin
    w_n = '0;
    v_n = '0;
    idx = '0;
    for (int r = 0; r < NB; r++) begin
      if (t >= TW'(r) && (t - TW'(r)) < TW'(k)) begin
        idx    = t - TW'(r);
        v_n[r] = 1'b1;
        w_n[r] = bank[r][idx[AW-1:0]];
      end
    end
  end
endmodule

module operand_skew_loader #(
  parameter int D_W   = 8,
  parameter int ROWS  = 2,
  parameter int COLS  = 2,
  parameter int DEPTH = 8,
  parameter int LANES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load_en,
  input  logic [LANES-1:0]            ser_x,
  input  logic [LANES-1:0]            ser_y,
  input  logic [$clog2(DEPTH+1)-1:0]  k_len,
  input  logic                        start,
  input  logic                        keep,
  input  logic                        stall,
  output logic [ROWS*D_W-1:0]         out_x_flat,
  output logic [COLS*D_W-1:0]         out_y_flat,
  output logic [ROWS-1:0]             out_vx,
  output logic [COLS-1:0]             out_vy,
  output logic                        busy,
  output logic                        loaded,
  output logic                        done,
  output logic                        load_err
);
  localparam int M  = (ROWS > COLS) ? ROWS : COLS;
  localparam int KW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(DEPTH + M + 1);

  typedef enum logic [1:0] {IDLE, LOAD, XFER} state_t;

  state_t        state;
  logic [KW-1:0] k_r;
  logic [TW-1:0] t, last1;
  logic          keep_r, ld, clr, issue, k_bad;
  logic          xc, yc, xo, yo;

  assign ld    = (state == LOAD) && load_en;
  assign clr   = (state == IDLE) && load_en;
  assign issue = (state == XFER) && !stall;
  assign k_bad = (k_len == '0) || (k_len > KW'(DEPTH));
  // One step past the final beat: that issue clears the outputs and ends XFER.
  assign last1 = TW'(k_r) + TW'(M - 1);

  osl_stream #(.D_W(D_W), .NB(ROWS), .DEPTH(DEPTH), .LANES(LANES), .KW(KW), .TW(TW)) u_x (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ser(ser_x), .k(k_r), .t(t), .issue(issue),
    .words(out_x_flat), .valid(out_vx), .complete(xc), .ovf(xo));

  osl_stream #(.D_W(D_W), .NB(COLS), .DEPTH(DEPTH), .LANES(LANES), .KW(KW), .TW(TW)) u_y (
    .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ser(ser_y), .k(k_r), .t(t), .issue(issue),
    .words(out_y_flat), .valid(out_vy), .complete(yc), .ovf(yo));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      k_r      <= '0;
      t        <= '0;
      keep_r   <= 1'b0;
      busy     <= 1'b0;
      loaded   <= 1'b0;
      done     <= 1'b0;
      load_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (load_en) begin
            state    <= LOAD;
            busy     <= 1'b1;
            load_err <= k_bad;
            k_r      <= (k_len == '0) ? KW'(1) : (k_len > KW'(DEPTH)) ? KW'(DEPTH) : k_len;
          end else if (start && loaded) begin
            state  <= XFER;
            busy   <= 1'b1;
            t      <= '0;
            keep_r <= keep;
          end
        end
        LOAD: begin
          if (xo || yo) load_err <= 1'b1;
          if (!load_en) begin
            state  <= IDLE;
            busy   <= 1'b0;
            loaded <= xc && yc;
            if (!(xc && yc)) load_err <= 1'b1;
          end
        end
        XFER: begin
          if (!stall) begin
            t <= t + 1'b1;
            if (t == last1) begin
              state  <= IDLE;
              busy   <= 1'b0;
              done   <= 1'b1;
              loaded <= keep_r;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_operand_skew_loader.sv
// Directed/randomised bench for operand_skew_loader (3 rows, 2 cols, 4 lanes),
// checking every output cycle against a wavefront model built from the loaded words.

module tb_operand_skew_loader;
  localparam int DW = 8, ROWS = 3, COLS = 2, DEPTH = 8, LANES = 4;
  localparam int CPW = DW / LANES;
  localparam int M = 3;

  logic clk = 1'b0, rst = 1'b0;
  logic load_en = 0, start = 0, keep = 0, stall = 0;
  logic [LANES-1:0] ser_x = '0, ser_y = '0;
  logic [3:0] k_len = '0;
  logic [ROWS*DW-1:0] out_x_flat;
  logic [COLS*DW-1:0] out_y_flat;
  logic [ROWS-1:0] out_vx;
  logic [COLS-1:0] out_vy;
  logic busy, loaded, done, load_err;

  int total = 0, bad = 0;
  int kcur = 1;
  logic [DW-1:0] xs [32];
  logic [DW-1:0] ys [32];

  operand_skew_loader #(.D_W(DW), .ROWS(ROWS), .COLS(COLS), .DEPTH(DEPTH), .LANES(LANES)) dut (
    .clk(clk), .rst(rst), .load_en(load_en), .ser_x(ser_x), .ser_y(ser_y), .k_len(k_len),
    .start(start), .keep(keep), .stall(stall), .out_x_flat(out_x_flat), .out_y_flat(out_y_flat),
    .out_vx(out_vx), .out_vy(out_vy), .busy(busy), .loaded(loaded), .done(done), .load_err(load_err));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wavefront model: lane r carries word (beat - r) of its bank when 0 <= beat-r < K.
  function automatic logic [ROWS*DW-1:0] ex_x(input int beat);
    logic [ROWS*DW-1:0] e = '0;
    for (int r = 0; r < ROWS; r++)
      if (beat - r >= 0 && beat - r < kcur) e[r*DW +: DW] = xs[r*kcur + beat - r];
    return e;
  endfunction
  function automatic logic [COLS*DW-1:0] ex_y(input int beat);
    logic [COLS*DW-1:0] e = '0;
    for (int c = 0; c < COLS; c++)
      if (beat - c >= 0 && beat - c < kcur) e[c*DW +: DW] = ys[c*kcur + beat - c];
    return e;
  endfunction
  function automatic logic [7:0] ex_v(input int beat, input int n);
    logic [7:0] e = '0;
    for (int r = 0; r < n; r++) if (beat - r >= 0 && beat - r < kcur) e[r] = 1'b1;
    return e;
  endfunction

  task automatic do_load(input int kl, input int nw, input bit partial, input bit with_start);
    int  keff;
    bit  kbad, lx, lerr;
    kbad = (kl == 0) || (kl > DEPTH);
    keff = (kl == 0) ? 1 : (kl > DEPTH) ? DEPTH : kl;
    for (int i = 0; i < nw; i++) begin
      xs[i] = DW'($urandom);
      ys[i] = DW'($urandom);
    end
    @(negedge clk);
    load_en = 1; k_len = 4'(kl); start = with_start; keep = 1;
    @(negedge clk);
    start = 0; keep = 0;
    chk("load_busy", 64'(busy), 64'(1));
    chk("load_err_entry", 64'(load_err), 64'(kbad));
    chk("load_vx_zero", 64'(out_vx), 64'(0));
    for (int i = 0; i < nw; i++)
      for (int c = 0; c < CPW; c++) begin
        ser_x = xs[i][c*LANES +: LANES];
        ser_y = ys[i][c*LANES +: LANES];
        @(negedge clk);
      end
    if (partial) begin
      ser_x = 4'hf; ser_y = 4'hf;
      @(negedge clk);
    end
    chk("load_vy_zero", 64'(out_vy), 64'(0));
    load_en = 0; ser_x = '0; ser_y = '0;
    @(negedge clk);
    lx   = (nw >= ROWS*keff) && (nw >= COLS*keff);
    lerr = kbad || !lx || (nw > ROWS*keff) || (nw > COLS*keff);
    chk("load_exit_busy", 64'(busy), 64'(0));
    chk("loaded", 64'(loaded), 64'(lx));
    chk("load_err", 64'(load_err), 64'(lerr));
    kcur = keff;
  endtask

  task automatic do_xfer(input int stall_at, input int stall_n, input bit kp);
    int issued = -1, left = stall_n, nb = kcur + M - 1;
    bit st, fin = 0;
    @(negedge clk);
    start = 1; keep = kp;
    @(negedge clk);
    start = 0; keep = 0;
    chk("xfer_busy", 64'(busy), 64'(1));
    chk("xfer_pre_vx", 64'(out_vx), 64'(0));
    for (int cyc = 0; cyc < 200 && !fin; cyc++) begin
      st = (issued == stall_at) && (left > 0);
      if (st) left--;
      stall = st;
      @(negedge clk);
      stall = 0;
      if (!st) issued++;
      if (issued < nb) begin
        chk($sformatf("x_b%0d", issued), 64'(out_x_flat), 64'(ex_x(issued)));
        chk($sformatf("vx_b%0d", issued), 64'(out_vx), 64'(ex_v(issued, ROWS)));
        chk($sformatf("y_b%0d", issued), 64'(out_y_flat), 64'(ex_y(issued)));
        chk($sformatf("vy_b%0d", issued), 64'(out_vy), 64'(ex_v(issued, COLS)));
        chk("xfer_busy_mid", 64'(busy), 64'(1));
        chk("xfer_done_early", 64'(done), 64'(0));
      end else begin
        chk("done_pulse", 64'(done), 64'(1));
        chk("done_busy", 64'(busy), 64'(0));
        chk("done_clear", 64'({out_x_flat, out_y_flat, out_vx, out_vy}), 64'(0));
        fin = 1;
      end
    end
    chk("xfer_finished", 64'(fin), 64'(1));
    @(negedge clk);
    chk("done_one_cycle", 64'(done), 64'(0));
    chk("loaded_keep", 64'(loaded), 64'(kp));
  endtask

  task automatic start_ignored(input string tag);
    @(negedge clk);
    start = 1; keep = 1;
    @(negedge clk);
    start = 0; keep = 0;
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    @(negedge clk);
    chk({tag, "_vx"}, 64'({out_vx, out_vy}), 64'(0));
  endtask

  initial begin
    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_loaded", 64'(loaded), 64'(0));
    chk("rst_err", 64'(load_err), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_out", 64'({out_x_flat, out_y_flat, out_vx, out_vy}), 64'(0));
    rst = 1;
    start_ignored("start_unloaded");

    // K=2: exact X fill, Y overfills with the same number of word slots
    do_load(2, 6, 0, 0);
    do_xfer(-1, 0, 0);
    start_ignored("start_after_keep0");

    // K=3: 9 X words, skew over 5 beats; stall 3 cycles at beat1, replay with keep
    do_load(3, 9, 0, 0);
    do_xfer(1, 3, 1);
    do_xfer(-1, 0, 0);
    start_ignored("start_after_replay");

    // short load with trailing partial word
    do_load(2, 5, 1, 0);
    start_ignored("start_incomplete");

    // k_len=0 clamps to K=1
    do_load(0, 4, 0, 0);
    do_xfer(0, 2, 0);

    // k_len>DEPTH clamps to DEPTH; first assert load_en together with start while loaded
    do_load(3, 9, 0, 0);
    do_xfer(-1, 0, 1);
    do_load(9, 24, 0, 1);
    do_xfer(3, 1, 1);

    // asynchronous reset mid-transfer at beat1
    @(negedge clk);
    start = 1;
    @(negedge clk);
    start = 0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_vx", 64'(out_vx), 64'(ex_v(1, ROWS)));
    rst = 0;
    #1;
    chk("arst_out", 64'({out_x_flat, out_y_flat, out_vx, out_vy}), 64'(0));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_loaded", 64'(loaded), 64'(0));
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'(0));
    chk("post_rst_loaded", 64'(loaded), 64'(0));
    start_ignored("start_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
